dev_bridge: RTL and testbench

- CPU-side bridge for the MIPS micro-system device bus; the initiator end of the 2-bit devaddr / we / 32-bit in/out register interface used by peripherals.
- Decodes CPU addresses onto two timer-class devices (TC0, TC1) and runs a req/ready handshake with the CPU.
- Captures rising edges of device interrupt requests into pending bits, masks them, and drives registered hardware-interrupt lines to CP0.
- Bridge's own MASK/PENDING/STATUS registers sit in a third address window.

---
 rtl/dev_bridge_pkg.sv | 24 ++
 rtl/dev_bridge_irq_capture.sv | 43 ++++
 rtl/dev_bridge.sv | 132 +++++++++++++
 tb/tb_dev_bridge.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dev_bridge_pkg.sv
// Shared constants, FSM encoding and address-decode helper for the device bus bridge.
package dev_bridge_pkg;

  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] BRG_BASE = 32'h0000_7F20;

  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  typedef enum logic [1:0] {SEL_TC0, SEL_TC1, SEL_BRG, SEL_NONE} sel_e;

  // Each window is 16 bytes, so only bits [31:4] take part in the decode.
  function automatic sel_e decode(input logic [31:4] addr_hi);
    if (addr_hi == TC0_BASE[31:4]) return SEL_TC0;
    if (addr_hi == TC1_BASE[31:4]) return SEL_TC1;
    if (addr_hi == BRG_BASE[31:4]) return SEL_BRG;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/dev_bridge_irq_capture.sv
// Rising-edge interrupt capture into PENDING, MASK register and registered hw_int lines.
module dev_bridge_irq_capture
  import dev_bridge_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_irq,
  input  logic       i_mask_we,
  input  logic [1:0] i_mask_wdata,
  input  logic [1:0] i_pend_w1c,
  output logic [1:0] o_mask,
  output logic [1:0] o_pending,
  output logic [1:0] o_hw_int
);

  logic [1:0] r_irq_prev;
  logic [1:0] r_mask;
  logic [1:0] r_pending;
  logic [1:0] r_hw_int;
  logic [1:0] w_rise;

  assign w_rise = i_irq & ~r_irq_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_prev <= 2'b00;
      r_mask     <= 2'b00;
      r_pending  <= 2'b00;
      r_hw_int   <= 2'b00;
    end else begin
      r_irq_prev <= i_irq;
      if (i_mask_we) r_mask <= i_mask_wdata;
      // A fresh edge beats a same-cycle clear so no interrupt is lost.
      r_pending  <= (r_pending & ~i_pend_w1c) | w_rise;
      r_hw_int   <= r_pending & r_mask;
    end
  end

  assign o_mask    = r_mask;
  assign o_pending = r_pending;
  assign o_hw_int  = r_hw_int;

endmodule

// File: rtl/dev_bridge.sv
// CPU-side device bus bridge: decodes TC0/TC1/bridge windows and runs a 3-cycle req/ready access.
module dev_bridge
  import dev_bridge_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  output logic [1:0]  o_hw_int,
  output logic [1:0]  o_dev_addr,
  output logic [31:0] o_dev_wdata,
  output logic        o_dev_we0,
  output logic        o_dev_we1,
  input  logic [31:0] i_dev_rdata0,
  input  logic [31:0] i_dev_rdata1,
  input  logic        i_dev_irq0,
  input  logic        i_dev_irq1
);

  state_e      r_state;
  sel_e        r_sel;
  logic        r_we;
  logic [1:0]  r_dev_addr;
  logic [31:0] r_dev_wdata;
  logic        r_dev_we0;
  logic        r_dev_we1;
  logic [31:0] r_cpu_rdata;
  logic        r_cpu_ready;
  logic        r_bus_err;

  logic        w_brg_wr;
  logic        w_mask_we;
  logic [1:0]  w_pend_w1c;
  logic [1:0]  w_mask;
  logic [1:0]  w_pending;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^i_cpu_addr[1:0];

  assign w_brg_wr   = (r_state == StAccess) && r_we && (r_sel == SEL_BRG);
  assign w_mask_we  = w_brg_wr && (r_dev_addr == REG_MASK);
  assign w_pend_w1c = (w_brg_wr && (r_dev_addr == REG_PENDING)) ? r_dev_wdata[1:0] : 2'b00;

  always_comb begin
    w_rdata = 32'h0;
    unique case (r_sel)
      SEL_TC0: w_rdata = i_dev_rdata0;
      SEL_TC1: w_rdata = i_dev_rdata1;
      SEL_BRG: begin
        case (r_dev_addr)
          REG_MASK:    w_rdata = {30'h0, w_mask};
          REG_PENDING: w_rdata = {30'h0, w_pending};
          REG_STATUS:  w_rdata = {28'h0, i_dev_irq1, i_dev_irq0, 1'b0, r_bus_err};
          default:     w_rdata = 32'h0;
        endcase
      end
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_sel       <= SEL_NONE;
      r_we        <= 1'b0;
      r_dev_addr  <= 2'b00;
      r_dev_wdata <= 32'h0;
      r_dev_we0   <= 1'b0;
      r_dev_we1   <= 1'b0;
      r_cpu_rdata <= 32'h0;
      r_cpu_ready <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        StIdle: begin
          // The request is still held during the ready cycle; do not take it twice.
          if (i_cpu_req && !r_cpu_ready) begin
            r_we        <= i_cpu_we;
            r_sel       <= decode(i_cpu_addr[31:4]);
            r_dev_addr  <= i_cpu_addr[3:2];
            r_dev_wdata <= i_cpu_wdata;
            r_dev_we0   <= i_cpu_we && (decode(i_cpu_addr[31:4]) == SEL_TC0);
            r_dev_we1   <= i_cpu_we && (decode(i_cpu_addr[31:4]) == SEL_TC1);
            r_state     <= StAccess;
          end
        end
        StAccess: begin
          r_dev_we0 <= 1'b0;
          r_dev_we1 <= 1'b0;
          if (!r_we) r_cpu_rdata <= w_rdata;
          if (r_sel == SEL_NONE) begin
            r_bus_err <= 1'b1;
          end else if (w_brg_wr && (r_dev_addr == REG_STATUS) && r_dev_wdata[0]) begin
            r_bus_err <= 1'b0;
          end
          r_state <= StResp;
        end
        StResp: begin
          r_cpu_ready <= 1'b1;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  dev_bridge_irq_capture u_irq_capture (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_irq        ({i_dev_irq1, i_dev_irq0}),
    .i_mask_we    (w_mask_we),
    .i_mask_wdata (r_dev_wdata[1:0]),
    .i_pend_w1c   (w_pend_w1c),
    .o_mask       (w_mask),
    .o_pending    (w_pending),
    .o_hw_int     (o_hw_int)
  );

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_dev_addr  = r_dev_addr;
  assign o_dev_wdata = r_dev_wdata;
  assign o_dev_we0   = r_dev_we0;
  assign o_dev_we1   = r_dev_we1;

endmodule

// File: tb/tb_dev_bridge.sv
// Directed bench for dev_bridge with a read-data scoreboard and simple device models.
module tb_dev_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic [1:0]  hw_int, dev_addr;
  logic [31:0] dev_wdata, dev_rdata0, dev_rdata1;
  logic        dev_we0, dev_we1, dev_irq0, dev_irq1;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Device register files are modelled as combinational functions of dev_addr.
  assign dev_rdata0 = 32'hA000_0000 | {30'h0, dev_addr};
  assign dev_rdata1 = (dev_addr == 2'd1) ? 32'h0000_1234 : 32'h0000_BAD0;

  dev_bridge dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_rdata  (cpu_rdata),
    .o_cpu_ready  (cpu_ready),
    .o_hw_int     (hw_int),
    .o_dev_addr   (dev_addr),
    .o_dev_wdata  (dev_wdata),
    .o_dev_we0    (dev_we0),
    .o_dev_we1    (dev_we1),
    .i_dev_rdata0 (dev_rdata0),
    .i_dev_rdata1 (dev_rdata1),
    .i_dev_irq0   (dev_irq0),
    .i_dev_irq1   (dev_irq1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access; optionally raise dev_irq0 during the ACCESS cycle.
  task automatic bus(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input int exp_we0, input int exp_we1, input bit irq_hook);
    int n, c0, c1;
    bit done;
    logic [31:0] exp_v;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    n = 0; c0 = 0; c1 = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      if (irq_hook && n == 0) dev_irq0 = 1'b1;
      c0 += int'(dev_we0);
      c1 += int'(dev_we1);
      if (cpu_ready) begin
        done = 1'b1;
        check({tag, "_latency"}, n, 2);
        if (exp_q.size() == 0) begin
          check({tag, "_sb_empty"}, 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          if (!we) check({tag, "_rdata"}, cpu_rdata, exp_v);
        end
        cpu_req = 1'b0;
      end
      n++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 0, 1);
      cpu_req = 1'b0;
    end
    check({tag, "_we0_cycles"}, c0, exp_we0);
    check({tag, "_we1_cycles"}, c1, exp_we1);
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, cpu_ready, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dev_irq0 = 1'b0; dev_irq1 = 1'b0;
    #12;
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_outs", {cpu_rdata, dev_wdata}, 64'h0);
    check("rst_misc", {hw_int, dev_addr, dev_we0, dev_we1}, 6'h0);
    @(negedge clk); rst_n = 1'b1;

    bus("wr_tc0", 1'b1, 32'h0000_7F00, 32'h0000_0009, 32'h0, 1, 0, 1'b0);
    check("wr_tc0_devaddr", dev_addr, 2'd0);
    check("wr_tc0_devwdata", dev_wdata, 32'h9);

    bus("rd_tc1", 1'b0, 32'h0000_7F14, 32'h0, 32'h0000_1234, 0, 0, 1'b0);
    bus("rd_tc0", 1'b0, 32'h0000_7F08, 32'h0, 32'hA000_0002, 0, 0, 1'b0);
    bus("wr_tc1", 1'b1, 32'h0000_7F1C, 32'h55AA_0001, 32'h0, 0, 1, 1'b0);
    check("wr_tc1_devaddr", dev_addr, 2'd3);

    bus("wr_mask", 1'b1, 32'h0000_7F20, 32'h1, 32'h0, 0, 0, 1'b0);
    bus("rd_mask", 1'b0, 32'h0000_7F20, 32'h0, 32'h1, 0, 0, 1'b0);

    @(negedge clk); dev_irq0 = 1'b1; dev_irq1 = 1'b1;
    @(posedge clk); #1;
    check("hwint_before", hw_int, 2'b00);
    @(posedge clk); #1;
    check("hwint_after", hw_int, 2'b01);
    bus("rd_pend11", 1'b0, 32'h0000_7F24, 32'h0, 32'h3, 0, 0, 1'b0);

    bus("w1c_pend0", 1'b1, 32'h0000_7F24, 32'h1, 32'h0, 0, 0, 1'b0);
    bus("rd_pend10", 1'b0, 32'h0000_7F24, 32'h0, 32'h2, 0, 0, 1'b0);
    check("hwint_cleared", hw_int, 2'b00);

    @(negedge clk); dev_irq0 = 1'b0;
    repeat (2) @(posedge clk);
    bus("w1c_race", 1'b1, 32'h0000_7F24, 32'h1, 32'h0, 0, 0, 1'b1);
    bus("rd_race", 1'b0, 32'h0000_7F24, 32'h0, 32'h3, 0, 0, 1'b0);
    check("hwint_race", hw_int, 2'b01);

    bus("rd_unmapped", 1'b0, 32'h0000_7F40, 32'h0, 32'h0, 0, 0, 1'b0);
    bus("rd_status1", 1'b0, 32'h0000_7F28, 32'h0, {28'h0, dev_irq1, dev_irq0, 2'b01}, 0, 0,
        1'b0);
    bus("clr_status", 1'b1, 32'h0000_7F28, 32'h1, 32'h0, 0, 0, 1'b0);
    bus("rd_status0", 1'b0, 32'h0000_7F28, 32'h0, {28'h0, dev_irq1, dev_irq0, 2'b00}, 0, 0,
        1'b0);
    bus("rd_reg3", 1'b0, 32'h0000_7F2C, 32'h0, 32'h0, 0, 0, 1'b0);

    @(negedge clk); dev_irq0 = 1'b0; dev_irq1 = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F0C; cpu_wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    check("mid_we0_high", dev_we0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_we0_drop", dev_we0, 1'b0);
    cpu_req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_no_ready", cpu_ready, 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    check("post_rst_dev", {dev_addr, dev_wdata}, 34'h0);
    check("post_rst_hwint", hw_int, 2'b00);
    bus("post_rd_mask", 1'b0, 32'h0000_7F20, 32'h0, 32'h0, 0, 0, 1'b0);
    bus("post_rd_pend", 1'b0, 32'h0000_7F24, 32'h0, 32'h0, 0, 0, 1'b0);
    bus("post_rd_stat", 1'b0, 32'h0000_7F28, 32'h0, 32'h0, 0, 0, 1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
